vdc_host_master: RTL
====================

# vdc_host_master

Bus initiator for the VDC's two-address host port: accepts high-level register and RAM-data commands and turns them into the cycle-accurate select/data access sequences the VDC expects, with status polling for RAM accesses. It sits between an internal requester (ROM loader, debug/OSD path, or a soft CPU shim) and the VDC's `cs`/`rs`/`we`/`db_in`/`db_out` pins, on the same `clk` and `enableBus` strobe as the VDC.

## Interface
- `POLL_LIMIT`, 255: maximum status reads while waiting for ready before aborting (1..255).
- `clk`  in  1  system clock. One clock for the whole block.
- `reset`  in  1  synchronous, active-high.
- `enableBus`  in  1  bus-phase strobe shared with the VDC; accesses complete only on cycles with `enableBus`=1.
- `cmd_valid`  in  1  command request.
- `cmd_ready`  out  1  high only in IDLE; command accepted when `cmd_valid & cmd_ready`.
- `cmd_op`  in  2  0=reg write, 1=reg read, 2=RAM write (via R31), 3=RAM read (via R31).
- `cmd_reg`  in  6  register number; ignored for ops 2/3 (forced to 31).
- `cmd_data`  in  8  write data for ops 0/2.
- `rsp_valid`  out  1  one-cycle completion pulse for every accepted command.
- `rsp_data`  out  8  read data for ops 1/3; 0xFF on timeout; 0x00 for writes.
- `rsp_err`  out  1  valid with `rsp_valid`; 1 = ready-poll timeout.
- `vdc_cs`, `vdc_rs`, `vdc_we`  out  1 each  to VDC `cs`, `rs`, `we`.
- `vdc_dout`  out  8  to VDC `db_in`.
- `vdc_din`  in  8  from VDC `db_out` (registered inside the VDC).

## Operation
- Access = one bus cycle: outputs `vdc_cs`=1 with `rs`/`we`/`dout` registered and held until a cycle with `enableBus`=1; that cycle completes the access; `vdc_cs` drops the next cycle. `vdc_cs` is never high for more than one `enableBus`=1 cycle per access.
- Read access: VDC registers `db_out` during the completing cycle; capture `vdc_din` the cycle after (CAPT state).
- Select cache: `sel_q[5:0]` + `sel_valid`. SEL access (rs=0, we=1, dout={2'b00,reg}) is skipped when `sel_valid & sel_q==reg`. Reset clears `sel_valid`.
- States: IDLE, SEL, POLL, PCAPT, DATA, DCAPT, RESP.
  - IDLE: latch op/reg/data on accept -> SEL (or skip to POLL for ops 2/3, DATA for 0/1 on cache hit).
  - SEL: on completion set `sel_q`, `sel_valid` -> POLL (ops 2/3) else DATA.
  - POLL: status read rs=0, we=0 -> PCAPT. PCAPT: `vdc_din[7]`=1 -> DATA; else increment 8-bit poll count; count==POLL_LIMIT -> RESP with err; else POLL.
  - DATA: rs=1, we=(op even), dout=data. Writes -> RESP; reads -> DCAPT -> RESP.
  - RESP: pulse `rsp_valid` one cycle -> IDLE.
- Poll counter cleared on each accept. Status read does not disturb selection cache.

## Timing
- Reset values: `cmd_ready`=1 one cycle after reset deasserts (0 during reset), `rsp_valid`=0, `rsp_data`=0x00, `rsp_err`=0, `vdc_cs`=0, `vdc_rs`=0, `vdc_we`=0, `vdc_dout`=0x00, state IDLE, `sel_valid`=0.
- Reset mid-command: bus released the next cycle (`vdc_cs`=0), command dropped, no `rsp_valid`.
- With `enableBus` every 2nd cycle: reg write (cache miss) accept -> `rsp_valid` ≤ 6 cycles; cache hit ≤ 4.
- `cmd_valid` while busy: ignored (`cmd_ready`=0); no queueing.
- `enableBus` held low: access stalls indefinitely with outputs stable; no timeout (timeout counts polls, not cycles).
- Back-to-back: next accept possible the cycle after RESP.

## Test plan
- Reset, then op0 reg=26 data=0xF0 -> bus sees rs=0/dout=0x1A then rs=1/dout=0xF0, one `enableBus` cycle each; `rsp_valid`, err=0.
- Repeat op0 reg=26 data=0x0F -> no select access (cache hit), single data write; VDC R26 reads 0x0F.
- op1 reg=12 after writing 0x20 -> select 0x0C, read; `rsp_data`=0x20.
- op2 data=0x41 with VDC status bit7 low for 3 polls -> 4 status reads, then R31 write; err=0.
- op3 with status bit7 stuck low, POLL_LIMIT=4 -> exactly 4 status reads, no R31 access, `rsp_err`=1, `rsp_data`=0xFF.
- Assert reset during POLL -> `vdc_cs`=0 next cycle, no `rsp_valid`, next op0 issues a select (cache invalidated).

Source files
------------

// File: rtl/vdc_host_master.sv
// Host-port initiator for the VDC: turns register and RAM-data commands
// into select/status/data bus accesses, with status polling for RAM ops.
`timescale 1ns/1ps
module vdc_host_master #(
    parameter int POLL_LIMIT = 255
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enableBus,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_op,
    input  logic [5:0] cmd_reg,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       rsp_err,
    output logic       vdc_cs,
    output logic       vdc_rs,
    output logic       vdc_we,
    output logic [7:0] vdc_dout,
    input  logic [7:0] vdc_din
);

    typedef enum logic [2:0] {
        IDLE, SEL, POLL, PCAPT, DATA, DCAPT, RESP
    } state_t;

    localparam logic [7:0] LIMIT = 8'(POLL_LIMIT);

    state_t     state;
    logic [1:0] op_q;
    logic [5:0] reg_q;
    logic [7:0] data_q;
    logic [5:0] sel_q;
    logic       sel_valid;
    logic [7:0] poll_cnt;

    logic       accept;
    logic       done;
    logic       hit;
    logic [5:0] reg_eff;
    logic [7:0] poll_nxt;

    assign accept   = cmd_valid & cmd_ready;
    assign done     = vdc_cs & enableBus;
    assign reg_eff  = cmd_op[1] ? 6'd31 : cmd_reg;
    assign hit      = sel_valid && (sel_q == reg_eff);
    assign poll_nxt = poll_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data  <= 8'h00;
            rsp_err   <= 1'b0;
            vdc_cs    <= 1'b0;
            vdc_rs    <= 1'b0;
            vdc_we    <= 1'b0;
            vdc_dout  <= 8'h00;
            op_q      <= 2'd0;
            reg_q     <= 6'd0;
            data_q    <= 8'h00;
            sel_q     <= 6'd0;
            sel_valid <= 1'b0;
            poll_cnt  <= 8'd0;
        end else begin
            rsp_valid <= 1'b0;
            unique case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        cmd_ready <= 1'b0;
                        op_q      <= cmd_op;
                        reg_q     <= reg_eff;
                        data_q    <= cmd_data;
                        poll_cnt  <= 8'd0;
                        vdc_cs    <= 1'b1;
                        if (!hit) begin
                            state    <= SEL;
                            vdc_rs   <= 1'b0;
                            vdc_we   <= 1'b1;
                            vdc_dout <= {2'b00, reg_eff};
                        end else if (cmd_op[1]) begin
                            state    <= POLL;
                            vdc_rs   <= 1'b0;
                            vdc_we   <= 1'b0;
                            vdc_dout <= 8'h00;
                        end else begin
                            state    <= DATA;
                            vdc_rs   <= 1'b1;
                            vdc_we   <= ~cmd_op[0];
                            vdc_dout <= cmd_data;
                        end
                    end
                end
                SEL: begin
                    if (done) begin
                        vdc_cs    <= 1'b0;
                        sel_q     <= reg_q;
                        sel_valid <= 1'b1;
                        state     <= op_q[1] ? POLL : DATA;
                    end
                end
                // Each access starts with cs low for one cycle after the last.
                POLL: begin
                    if (!vdc_cs) begin
                        vdc_cs   <= 1'b1;
                        vdc_rs   <= 1'b0;
                        vdc_we   <= 1'b0;
                        vdc_dout <= 8'h00;
                    end else if (enableBus) begin
                        vdc_cs <= 1'b0;
                        state  <= PCAPT;
                    end
                end
                PCAPT: begin
                    if (vdc_din[7]) begin
                        state <= DATA;
                    end else begin
                        poll_cnt <= poll_nxt;
                        if (poll_nxt == LIMIT) begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 8'hFF;
                            rsp_err   <= 1'b1;
                        end else begin
                            state <= POLL;
                        end
                    end
                end
                DATA: begin
                    if (!vdc_cs) begin
                        vdc_cs   <= 1'b1;
                        vdc_rs   <= 1'b1;
                        vdc_we   <= ~op_q[0];
                        vdc_dout <= op_q[0] ? 8'h00 : data_q;
                    end else if (enableBus) begin
                        vdc_cs <= 1'b0;
                        if (op_q[0]) begin
                            state <= DCAPT;
                        end else begin
                            state     <= RESP;
                            rsp_valid <= 1'b1;
                            rsp_data  <= 8'h00;
                            rsp_err   <= 1'b0;
                        end
                    end
                end
                DCAPT: begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    rsp_data  <= vdc_din;
                    rsp_err   <= 1'b0;
                end
                RESP: begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
